// File: rtl/ppl_mdu_ctrl_pkg.sv
// ppl_mdu_ctrl_pkg: shared definitions for the iterative multiply/divide unit.
//   MD_* op codes        : encoding of mdOp driven by EX
//   MD_IDLE/CALC/FIXUP   : controller state encodings
//   md_ctx_t             : per-operation context latched at start
package ppl_mdu_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] MD_IDLE  = 2'd0;
    localparam logic [1:0] MD_CALC  = 2'd1;
    localparam logic [1:0] MD_FIXUP = 2'd2;

    // Context captured at op start and consumed in FIXUP.
    typedef struct packed {
        logic div;    // divide (1) or multiply (0)
        logic neg_q;  // negate product / quotient
        logic neg_r;  // negate remainder (dividend was negative)
        logic divz;   // divide-by-zero shortcut, acc already holds {HI, LO}
    } md_ctx_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ppl_md_step.sv
// ppl_md_step: one combinational iteration of the shared MDU datapath.
//   i_acc     : 2*WIDTH accumulator (mult: {partial, multiplier}; div: {rem, dividend/quot})
//   i_operand : multiplicand (mult) or divisor (div)
//   i_div     : 1 selects restoring-divide step, 0 selects shift-add step
//   o_acc     : accumulator after this iteration
module ppl_md_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_rsh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_div_acc;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
    assign w_mul_acc = i_acc[0] ? {w_sum, i_acc[WIDTH-1:1]}
                                : {1'b0, i_acc[2*WIDTH-1:1]};

    // Restoring divide: the remainder is always below the divisor, so the
    // shifted remainder fits in WIDTH+1 bits and the difference in WIDTH.
    assign w_rsh     = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge      = (w_rsh >= {1'b0, i_operand});
    assign w_rem     = w_ge ? WIDTH'(w_rsh - {1'b0, i_operand}) : w_rsh[WIDTH-1:0];
    assign w_div_acc = {w_rem, i_acc[WIDTH-2:0], w_ge};

    assign o_acc = i_div ? w_div_acc : w_mul_acc;

endmodule

// File: rtl/ppl_mdu_ctrl.sv
// ppl_mdu_ctrl: iterative multiply/divide controller owning HI/LO.
//   clock, resetn         : clock, async active-low reset
//   mdStart/mdOp/mdA/mdB  : op issue from EX (taken only when not stalled)
//   mdRead, mthi, mtlo    : HI/LO accesses from EX; mdWdata is MTHI/MTLO data
//   mdCancel              : flush, aborts an op in flight
//   mdStall               : combinational pipeline freeze request
//   mdBusy                : op in flight
//   mdDone, mdDivZero     : one-cycle completion pulses
//   hi, lo                : architectural HI/LO
module ppl_mdu_ctrl
    import ppl_mdu_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] DIVZERO_LO = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             mdStart,
    input  logic [1:0]       mdOp,
    input  logic [WIDTH-1:0] mdA,
    input  logic [WIDTH-1:0] mdB,
    input  logic             mdRead,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mdWdata,
    input  logic             mdCancel,
    output logic             mdStall,
    output logic             mdBusy,
    output logic             mdDone,
    output logic             mdDivZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [1:0]       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt,   w_cnt_nxt;
    logic [AW-1:0]    r_acc,   w_acc_nxt;
    logic [WIDTH-1:0] r_opnd,  w_opnd_nxt;
    md_ctx_t          r_ctx,   w_ctx_nxt;
    logic [WIDTH-1:0] r_hi,    w_hi_nxt;
    logic [WIDTH-1:0] r_lo,    w_lo_nxt;
    logic             r_done,  w_done_nxt;
    logic             r_dz,    w_dz_nxt;

    logic             w_signed, w_neg_a, w_neg_b, w_is_div;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [AW-1:0]    w_step_acc, w_prod;
    logic [WIDTH-1:0] w_quot, w_rem;

    // Operand magnitude and sign capture at issue.
    assign w_signed = op_is_signed(mdOp);
    assign w_is_div = op_is_div(mdOp);
    assign w_neg_a  = w_signed & mdA[WIDTH-1];
    assign w_neg_b  = w_signed & mdB[WIDTH-1];
    assign w_abs_a  = w_neg_a ? -mdA : mdA;
    assign w_abs_b  = w_neg_b ? -mdB : mdB;

    // Sign correction applied in FIXUP.
    assign w_prod = r_ctx.neg_q ? -r_acc : r_acc;
    assign w_quot = r_ctx.neg_q ? -r_acc[WIDTH-1:0]  : r_acc[WIDTH-1:0];
    assign w_rem  = r_ctx.neg_r ? -r_acc[AW-1:WIDTH] : r_acc[AW-1:WIDTH];

    ppl_md_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_div     (r_ctx.div),
        .o_acc     (w_step_acc)
    );

    // State and datapath registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_ctx   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_opnd  <= w_opnd_nxt;
            r_ctx   <= w_ctx_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_done  <= w_done_nxt;
            r_dz    <= w_dz_nxt;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_opnd_nxt  = r_opnd;
        w_ctx_nxt   = r_ctx;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = 1'b0;

        case (r_state)
            MD_IDLE: begin
                if (mdStart && !mdCancel) begin
                    // Start wins over a coincident MTHI/MTLO.
                    w_cnt_nxt       = CW'(WIDTH - 1);
                    w_ctx_nxt.div   = w_is_div;
                    w_ctx_nxt.neg_q = w_neg_a ^ w_neg_b;
                    w_ctx_nxt.neg_r = w_neg_a;
                    w_ctx_nxt.divz  = 1'b0;
                    if (w_is_div && (mdB == '0)) begin
                        w_ctx_nxt.divz = 1'b1;
                        w_acc_nxt      = {mdA, DIVZERO_LO};
                        w_state_nxt    = MD_FIXUP;
                    end else if (w_is_div) begin
                        w_acc_nxt   = {{WIDTH{1'b0}}, w_abs_a};
                        w_opnd_nxt  = w_abs_b;
                        w_state_nxt = MD_CALC;
                    end else begin
                        w_acc_nxt   = {{WIDTH{1'b0}}, w_abs_b};
                        w_opnd_nxt  = w_abs_a;
                        w_state_nxt = MD_CALC;
                    end
                end else if (!mdStart) begin
                    if (mthi) w_hi_nxt = mdWdata;
                    if (mtlo) w_lo_nxt = mdWdata;
                end
            end

            MD_CALC: begin
                if (mdCancel) begin
                    w_state_nxt = MD_IDLE;
                end else begin
                    w_acc_nxt = w_step_acc;
                    if (r_cnt == '0) w_state_nxt = MD_FIXUP;
                    else             w_cnt_nxt   = r_cnt - 1'b1;
                end
            end

            MD_FIXUP: begin
                w_state_nxt = MD_IDLE;
                if (!mdCancel) begin
                    w_done_nxt = 1'b1;
                    w_dz_nxt   = r_ctx.divz;
                    if (r_ctx.divz) begin
                        w_hi_nxt = r_acc[AW-1:WIDTH];
                        w_lo_nxt = r_acc[WIDTH-1:0];
                    end else if (r_ctx.div) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quot;
                    end else begin
                        w_hi_nxt = w_prod[AW-1:WIDTH];
                        w_lo_nxt = w_prod[WIDTH-1:0];
                    end
                end
            end

            default: w_state_nxt = MD_IDLE;
        endcase
    end

    assign mdBusy    = (r_state != MD_IDLE);
    assign mdStall   = mdBusy & (mdStart | mdRead | mthi | mtlo);
    assign mdDone    = r_done;
    assign mdDivZero = r_dz;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
